// File: rtl/code_chip_gen_if.sv
// Bus between the channel scheduler / code NCO and the code chip generator.
// The master side drives the NCO strobe, the per-channel seeds and the
// save/restore load port; the slave side (the generator) returns its state
// and the early/prompt/late chips.
interface code_chip_gen_if #(
    parameter int CHIP_CNT_W  = 11,
    parameter int EPOCH_CNT_W = 5
);
    logic                   overflow;
    logic [9:0]             g1_init;
    logic [9:0]             g2_init;
    logic                   state_load_en;
    logic [9:0]             g1_i;
    logic [9:0]             g2_i;
    logic [CHIP_CNT_W-1:0]  chip_count_i;
    logic [EPOCH_CNT_W-1:0] epoch_count_i;
    logic [1:0]             pl_i;
    logic [9:0]             g1_o;
    logic [9:0]             g2_o;
    logic [CHIP_CNT_W-1:0]  chip_count_o;
    logic [EPOCH_CNT_W-1:0] epoch_count_o;
    logic                   code_early;
    logic                   code_prompt;
    logic                   code_late;
    logic                   epoch;

    modport master (
        output overflow, g1_init, g2_init, state_load_en,
               g1_i, g2_i, chip_count_i, epoch_count_i, pl_i,
        input  g1_o, g2_o, chip_count_o, epoch_count_o,
               code_early, code_prompt, code_late, epoch
    );

    modport slave (
        input  overflow, g1_init, g2_init, state_load_en,
               g1_i, g2_i, chip_count_i, epoch_count_i, pl_i,
        output g1_o, g2_o, chip_count_o, epoch_count_o,
               code_early, code_prompt, code_late, epoch
    );
endinterface

// File: rtl/code_chip_gen.sv
// C/A-style Gold code chip generator. Each code-NCO overflow advances the
// G1/G2 LFSR pair by one chip and shifts the early chip into prompt/late.
// Tracks chip index within the code period, the code-epoch pulse and the
// epoch (bit-sync) counter. All state is loadable for channel time-slicing.
module code_chip_gen #(
    parameter int CODE_LENGTH   = 1023,
    parameter int CHIP_CNT_W    = 11,
    parameter int EPOCH_CNT_MAX = 19,
    parameter int EPOCH_CNT_W   = 5
) (
    input logic             clk,
    input logic             rst,
    code_chip_gen_if.slave  bus
);

    localparam logic [CHIP_CNT_W-1:0]  LAST_CHIP  = CHIP_CNT_W'(CODE_LENGTH - 1);
    localparam logic [EPOCH_CNT_W-1:0] LAST_EPOCH = EPOCH_CNT_W'(EPOCH_CNT_MAX);

    // G1 polynomial: feedback from stages 3 and 10 into stage 1.
    function automatic logic [9:0] g1_shift(input logic [9:0] g);
        g1_shift = {g[8:0], g[2] ^ g[9]};
    endfunction

    // G2 polynomial: feedback from stages 2,3,6,8,9,10 into stage 1.
    function automatic logic [9:0] g2_shift(input logic [9:0] g);
        g2_shift = {g[8:0], g[1] ^ g[2] ^ g[5] ^ g[7] ^ g[8] ^ g[9]};
    endfunction

    logic [9:0]             g1_p0,    g1_nxt;
    logic [9:0]             g2_p0,    g2_nxt;
    logic [CHIP_CNT_W-1:0]  chip_p0,  chip_nxt;
    logic [EPOCH_CNT_W-1:0] ecnt_p0,  ecnt_nxt;
    logic                   prompt_p0, prompt_nxt;
    logic                   late_p0,   late_nxt;
    logic                   epoch_p0,  epoch_nxt;
    logic                   early;

    // Early chip comes straight off the stage-10 outputs of both LFSRs.
    assign early = g1_p0[9] ^ g2_p0[9];

    // Next-state selection: load beats overflow; otherwise hold.
    always_comb begin
        g1_nxt     = g1_p0;
        g2_nxt     = g2_p0;
        chip_nxt   = chip_p0;
        ecnt_nxt   = ecnt_p0;
        prompt_nxt = prompt_p0;
        late_nxt   = late_p0;
        epoch_nxt  = 1'b0;
        if (bus.state_load_en) begin
            g1_nxt     = bus.g1_i;
            g2_nxt     = bus.g2_i;
            chip_nxt   = bus.chip_count_i;
            ecnt_nxt   = bus.epoch_count_i;
            prompt_nxt = bus.pl_i[1];
            late_nxt   = bus.pl_i[0];
        end else if (bus.overflow) begin
            prompt_nxt = early;
            late_nxt   = prompt_p0;
            if (chip_p0 == LAST_CHIP) begin
                // Period wrap: restart both registers from the channel seeds.
                g1_nxt    = bus.g1_init;
                g2_nxt    = bus.g2_init;
                chip_nxt  = '0;
                epoch_nxt = 1'b1;
                ecnt_nxt  = (ecnt_p0 == LAST_EPOCH) ? '0 : ecnt_p0 + EPOCH_CNT_W'(1);
            end else begin
                g1_nxt   = g1_shift(g1_p0);
                g2_nxt   = g2_shift(g2_p0);
                chip_nxt = chip_p0 + CHIP_CNT_W'(1);
            end
        end
    end

    // Generator state register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            g1_p0     <= 10'h3FF;
            g2_p0     <= 10'h3FF;
            chip_p0   <= '0;
            ecnt_p0   <= '0;
            prompt_p0 <= 1'b0;
            late_p0   <= 1'b0;
            epoch_p0  <= 1'b0;
        end else begin
            g1_p0     <= g1_nxt;
            g2_p0     <= g2_nxt;
            chip_p0   <= chip_nxt;
            ecnt_p0   <= ecnt_nxt;
            prompt_p0 <= prompt_nxt;
            late_p0   <= late_nxt;
            epoch_p0  <= epoch_nxt;
        end
    end

    assign bus.g1_o          = g1_p0;
    assign bus.g2_o          = g2_p0;
    assign bus.chip_count_o  = chip_p0;
    assign bus.epoch_count_o = ecnt_p0;
    assign bus.code_early    = early;
    assign bus.code_prompt   = prompt_p0;
    assign bus.code_late     = late_p0;
    assign bus.epoch         = epoch_p0;

endmodule

// File: tb/tb_code_chip_gen.sv
// Testbench for code_chip_gen: directed scenarios plus randomized traffic,
// all compared against a stage-list LFSR reference model.
module tb_code_chip_gen;

    localparam int CODE_LENGTH   = 1023;
    localparam int CHIP_CNT_W    = 11;
    localparam int EPOCH_CNT_MAX = 19;
    localparam int EPOCH_CNT_W   = 5;

    typedef bit stages_t [1:10];

    logic clk;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    code_chip_gen_if #(.CHIP_CNT_W(CHIP_CNT_W), .EPOCH_CNT_W(EPOCH_CNT_W)) bus ();

    code_chip_gen #(
        .CODE_LENGTH  (CODE_LENGTH),
        .CHIP_CNT_W   (CHIP_CNT_W),
        .EPOCH_CNT_MAX(EPOCH_CNT_MAX),
        .EPOCH_CNT_W  (EPOCH_CNT_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
        $fatal(1);
    end

    // Reference model: registers as lists of stages 1..10, taps by stage number.
    stages_t m_g1, m_g2;
    int      m_chip, m_ecnt;
    bit      m_p, m_l, m_ep;
    int      g1_taps [2] = '{3, 10};
    int      g2_taps [6] = '{2, 3, 6, 8, 9, 10};

    function automatic stages_t unpack_v(input logic [9:0] v);
        stages_t s;
        for (int k = 1; k <= 10; k++) s[k] = v[k-1];
        return s;
    endfunction

    function automatic logic [9:0] pack_v(input stages_t s);
        logic [9:0] v;
        for (int k = 1; k <= 10; k++) v[k-1] = s[k];
        return v;
    endfunction

    function automatic bit model_early();
        return m_g1[10] ^ m_g2[10];
    endfunction

    function automatic logic [38:0] model_vec();
        return {pack_v(m_g1), pack_v(m_g2), CHIP_CNT_W'(m_chip), EPOCH_CNT_W'(m_ecnt),
                m_p, m_l, m_ep};
    endfunction

    function automatic logic [38:0] dut_vec();
        return {bus.g1_o, bus.g2_o, bus.chip_count_o, bus.epoch_count_o,
                bus.code_prompt, bus.code_late, bus.epoch};
    endfunction

    task automatic model_clock(input bit r, input bit ld, input bit ov);
        bit e, f1, f2;
        if (r) begin
            for (int k = 1; k <= 10; k++) begin m_g1[k] = 1'b1; m_g2[k] = 1'b1; end
            m_chip = 0; m_ecnt = 0; m_p = 0; m_l = 0; m_ep = 0;
        end else if (ld) begin
            m_g1 = unpack_v(bus.g1_i);
            m_g2 = unpack_v(bus.g2_i);
            m_chip = int'(bus.chip_count_i);
            m_ecnt = int'(bus.epoch_count_i);
            m_p = bus.pl_i[1];
            m_l = bus.pl_i[0];
            m_ep = 0;
        end else if (ov) begin
            e = model_early();
            m_l = m_p;
            m_p = e;
            if (m_chip == CODE_LENGTH - 1) begin
                m_g1 = unpack_v(bus.g1_init);
                m_g2 = unpack_v(bus.g2_init);
                m_chip = 0;
                m_ep = 1;
                m_ecnt = (m_ecnt + 1) % (EPOCH_CNT_MAX + 1);
            end else begin
                f1 = 0; f2 = 0;
                foreach (g1_taps[i]) f1 ^= m_g1[g1_taps[i]];
                foreach (g2_taps[i]) f2 ^= m_g2[g2_taps[i]];
                for (int k = 10; k >= 2; k--) begin m_g1[k] = m_g1[k-1]; m_g2[k] = m_g2[k-1]; end
                m_g1[1] = f1;
                m_g2[1] = f2;
                m_chip = (m_chip + 1) % (1 << CHIP_CNT_W);
                m_ep = 0;
            end
        end else begin
            m_ep = 0;
        end
    endtask

    // One clock: present controls, let the edge happen, advance the model.
    task automatic step(input bit r, input bit ld, input bit ov);
        rst = r;
        bus.state_load_en = ld;
        bus.overflow = ov;
        @(posedge clk);
        model_clock(r, ld, ov);
        #1;
        rst = 1'b0;
        bus.state_load_en = 1'b0;
        bus.overflow = 1'b0;
    endtask

    task automatic load_state(input logic [9:0] g1, input logic [9:0] g2, input int chip,
                              input int ecnt, input logic [1:0] pl, input bit ov);
        bus.g1_i = g1;
        bus.g2_i = g2;
        bus.chip_count_i = CHIP_CNT_W'(chip);
        bus.epoch_count_i = EPOCH_CNT_W'(ecnt);
        bus.pl_i = pl;
        step(1'b0, 1'b1, ov);
    endtask

    task automatic test_reset();
        int epochs = 0;
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        checks++;
        if (dut_vec() !== {10'h3FF, 10'h3FF, 11'd0, 5'd0, 1'b0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_state: got %h expected %h", dut_vec(),
                     {10'h3FF, 10'h3FF, 11'd0, 5'd0, 3'b000});
        end
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 1'b0, 1'b0);
            if (bus.epoch) epochs++;
            checks++;
            if (dut_vec() !== model_vec() || bus.code_early !== 1'b0) begin
                errors++;
                $display("FAIL reset_idle[%0d]: got %h/%b expected %h/0", i, dut_vec(),
                         bus.code_early, model_vec());
            end
        end
        checks++;
        if (epochs !== 0) begin
            errors++;
            $display("FAIL reset_idle_epoch: got %0d pulses expected 0", epochs);
        end
    endtask

    task automatic test_prn1();
        bit exp_chips [10] = '{1, 1, 0, 0, 1, 0, 0, 0, 0, 0};
        bus.g1_init = 10'h3FF;
        bus.g2_init = 10'h0DF;
        load_state(10'h3FF, 10'h0DF, 0, 0, 2'b00, 1'b0);
        for (int k = 0; k < 10; k++) begin
            checks++;
            if (bus.code_early !== exp_chips[k]) begin
                errors++;
                $display("FAIL prn1_early[%0d]: got %b expected %b", k, bus.code_early, exp_chips[k]);
            end
            step(1'b0, 1'b0, 1'b1);
            checks++;
            if (bus.code_prompt !== exp_chips[k] ||
                (k >= 1 && bus.code_late !== exp_chips[(k >= 1) ? k - 1 : 0])) begin
                errors++;
                $display("FAIL prn1_pl[%0d]: got p=%b l=%b expected p=%b l=%b", k,
                         bus.code_prompt, bus.code_late, exp_chips[k],
                         exp_chips[(k >= 1) ? k - 1 : 0]);
            end
            checks++;
            if (dut_vec() !== model_vec()) begin
                errors++;
                $display("FAIL prn1_state[%0d]: got %h expected %h", k, dut_vec(), model_vec());
            end
        end
    endtask

    task automatic test_wrap();
        bus.g1_init = 10'(($urandom % 1023) + 1);
        bus.g2_init = 10'(($urandom % 1023) + 1);
        load_state(10'($urandom), 10'($urandom), 1021, 19, 2'b01, 1'b0);
        step(1'b0, 1'b0, 1'b1);
        checks++;
        if (bus.chip_count_o !== 11'd1022 || bus.epoch !== 1'b0 || bus.epoch_count_o !== 5'd19) begin
            errors++;
            $display("FAIL wrap_first: got chip=%0d epoch=%b ecnt=%0d expected 1022 0 19",
                     bus.chip_count_o, bus.epoch, bus.epoch_count_o);
        end
        step(1'b0, 1'b0, 1'b1);
        checks++;
        if ({bus.chip_count_o, bus.epoch, bus.epoch_count_o, bus.g1_o, bus.g2_o} !==
            {11'd0, 1'b1, 5'd0, bus.g1_init, bus.g2_init}) begin
            errors++;
            $display("FAIL wrap_second: got chip=%0d epoch=%b ecnt=%0d g1=%h g2=%h expected 0 1 0 %h %h",
                     bus.chip_count_o, bus.epoch, bus.epoch_count_o, bus.g1_o, bus.g2_o,
                     bus.g1_init, bus.g2_init);
        end
        checks++;
        if (dut_vec() !== model_vec()) begin
            errors++;
            $display("FAIL wrap_model: got %h expected %h", dut_vec(), model_vec());
        end
        step(1'b0, 1'b0, 1'b0);
        checks++;
        if (bus.epoch !== 1'b0) begin
            errors++;
            $display("FAIL wrap_epoch_drop: got %b expected 0", bus.epoch);
        end
    endtask

    task automatic test_period();
        int epochs = 0;
        int bad = 0;
        bus.g1_init = 10'h3FF;
        bus.g2_init = 10'h0DF;
        load_state(10'h3FF, 10'h0DF, 0, 3, 2'b00, 1'b0);
        for (int i = 0; i < CODE_LENGTH; i++) begin
            checks++;
            if (bus.code_early !== model_early()) begin
                errors++; bad++;
                if (bad < 5)
                    $display("FAIL period_chip[%0d]: got %b expected %b", i, bus.code_early, model_early());
            end
            step(1'b0, 1'b0, 1'b1);
            if (bus.epoch) epochs++;
            checks++;
            if (dut_vec() !== model_vec()) begin
                errors++; bad++;
                if (bad < 5)
                    $display("FAIL period_state[%0d]: got %h expected %h", i, dut_vec(), model_vec());
            end
        end
        checks++;
        if ({bus.g1_o, bus.g2_o, bus.chip_count_o, bus.epoch_count_o} !==
            {10'h3FF, 10'h0DF, 11'd0, 5'd4} || epochs !== 1) begin
            errors++;
            $display("FAIL period_end: got g1=%h g2=%h chip=%0d ecnt=%0d pulses=%0d expected 3ff 0df 0 4 1",
                     bus.g1_o, bus.g2_o, bus.chip_count_o, bus.epoch_count_o, epochs);
        end
    endtask

    task automatic test_collision();
        logic [9:0] g1v, g2v;
        g1v = 10'($urandom);
        g2v = 10'($urandom);
        step(1'b0, 1'b0, 1'b1);
        load_state(g1v, g2v, 500, 7, 2'b10, 1'b1);
        checks++;
        if (dut_vec() !== {g1v, g2v, 11'd500, 5'd7, 1'b1, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL collision: got %h expected %h", dut_vec(),
                     {g1v, g2v, 11'd500, 5'd7, 3'b100});
        end
        checks++;
        if (dut_vec() !== model_vec()) begin
            errors++;
            $display("FAIL collision_model: got %h expected %h", dut_vec(), model_vec());
        end
    endtask

    task automatic test_sparse();
        logic [38:0] prev;
        load_state(10'($urandom), 10'($urandom), 100, 2, 2'b11, 1'b0);
        for (int c = 0; c < 30; c++) begin
            prev = dut_vec();
            step(1'b0, 1'b0, (c % 3) == 0);
            checks++;
            if (dut_vec() !== model_vec() || ((c % 3) != 0 && dut_vec() !== prev)) begin
                errors++;
                $display("FAIL sparse[%0d]: got %h expected %h", c, dut_vec(), model_vec());
            end
        end
        checks++;
        if (bus.chip_count_o !== 11'd110) begin
            errors++;
            $display("FAIL sparse_advance: got %0d expected 110", bus.chip_count_o);
        end
    endtask

    task automatic test_random();
        int bad = 0;
        bit r, ld, ov;
        bus.g1_init = 10'(($urandom % 1023) + 1);
        bus.g2_init = 10'(($urandom % 1023) + 1);
        for (int i = 0; i < 400; i++) begin
            r  = ($urandom % 60) == 0;
            ld = ($urandom % 12) == 0;
            ov = ($urandom % 2) == 0;
            if (ld) begin
                bus.g1_i = 10'($urandom);
                bus.g2_i = 10'($urandom);
                bus.chip_count_i = CHIP_CNT_W'(($urandom % 4 == 0) ? 1015 + ($urandom % 8)
                                                                   : $urandom % CODE_LENGTH);
                bus.epoch_count_i = EPOCH_CNT_W'($urandom % (EPOCH_CNT_MAX + 1));
                bus.pl_i = 2'($urandom);
            end
            checks++;
            if (bus.code_early !== model_early()) begin
                errors++; bad++;
                if (bad < 5)
                    $display("FAIL random_early[%0d]: got %b expected %b", i, bus.code_early, model_early());
            end
            step(r, ld, ov);
            checks++;
            if (dut_vec() !== model_vec()) begin
                errors++; bad++;
                if (bad < 5)
                    $display("FAIL random_state[%0d]: got %h expected %h", i, dut_vec(), model_vec());
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        bus.overflow = 1'b0;
        bus.state_load_en = 1'b0;
        bus.g1_init = 10'h3FF;
        bus.g2_init = 10'h3FF;
        bus.g1_i = '0;
        bus.g2_i = '0;
        bus.chip_count_i = '0;
        bus.epoch_count_i = '0;
        bus.pl_i = '0;
        model_clock(1'b1, 1'b0, 1'b0);
        test_reset();
        test_prn1();
        test_wrap();
        test_period();
        test_collision();
        test_sparse();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
